// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage: main + skid register with valid/ready handshake, flush and zeroed bubbles.
// Define PIPE_STATS_EN to add the stall/bubble statistics counters and their ports.
module pipe_stage_reg #(
  parameter int DATA_W = 112,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STATS_EN
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
`endif
  output logic [1:0]        dbg_state
);

  // Handshake: a beat moves on a rising edge where valid & ready are both high;
  // ready never depends combinationally on valid, and flush overrides both sides.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_main_q;
  logic [DATA_W-1:0] r_skid_q;
  logic              r_in_ready;
  logic              r_out_valid;

  logic w_accept;
  logic w_pop;

  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = r_out_valid & out_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= ST_EMPTY;
      r_main_q    <= '0;
      r_skid_q    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_main_q    <= '0;
      r_skid_q    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state     <= ST_ONE;
            r_main_q    <= in_data;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            r_main_q <= in_data;
          end else if (w_accept) begin
            // Downstream stalled: park the new beat behind the one on display.
            r_state     <= ST_TWO;
            r_skid_q    <= in_data;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
          end else if (w_pop) begin
            r_state     <= ST_EMPTY;
            r_main_q    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            r_state     <= ST_ONE;
            r_main_q    <= r_skid_q;
            r_skid_q    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_main_q    <= '0;
          r_skid_q    <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main_q;
  assign dbg_state = r_state;

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Counters stick at all-ones; stat_clr beats any increment in the same cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (stat_clr) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (r_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (!r_out_valid && (r_bubble_cnt != {CNT_W{1'b1}}))
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed test-plan sequences plus random traffic checked
// against a queue model of the stage contents (and counter model when PIPE_STATS_EN).
module tb_pipe_stage_reg;

  localparam int DATA_W = 112;
`ifdef PIPE_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              CLK;
  logic              nRST;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        dbg_state;
  logic              stat_clr;
`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] exp_q[$];
  int exp_stall  = 0;
  int exp_bubble = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
`ifdef PIPE_STATS_EN
    .stat_clr(stat_clr),
    .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DATA_W-1:0];
  endfunction

  // Outputs must reflect the modelled contents: the oldest entry is on display.
  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    check("out_valid", DATA_W'(out_valid), DATA_W'(sz > 0));
    check("in_ready", DATA_W'(in_ready), DATA_W'(sz < 2));
    check("out_data", out_data, (sz > 0) ? exp_q[0] : '0);
    check("state", DATA_W'(dbg_state), DATA_W'(sz));
`ifdef PIPE_STATS_EN
    check("stall_cnt", DATA_W'(stall_cnt), DATA_W'(exp_stall));
    check("bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(exp_bubble));
`endif
  endtask

  // Driver: called at a negedge; applies inputs for one edge, then checks at the next negedge.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
    int  sz;
    bit  acc, pp;
    in_valid  = v;
    in_data   = v ? d : rand_data();
    out_ready = r;
    flush     = f;
    sz  = exp_q.size();
    acc = v && (sz < 2);
    pp  = (sz > 0) && r;
    @(posedge CLK);
    if (stat_clr) begin
      exp_stall  = 0;
      exp_bubble = 0;
    end else begin
      if (sz > 0 && !r && exp_stall < CNT_MAX) exp_stall++;
      if (sz == 0 && exp_bubble < CNT_MAX) exp_bubble++;
    end
    if (f) begin
      exp_q.delete();
    end else begin
      if (pp) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(d);
    end
    @(negedge CLK);
    check_outputs();
  endtask

  // Asynchronous reset with random inputs; leaves nRST released at a negedge.
  task automatic do_reset(input int n);
    nRST      = 1'b0;
    in_valid  = 1'($urandom);
    in_data   = rand_data();
    out_ready = 1'($urandom);
    flush     = 1'($urandom);
    stat_clr  = 1'b0;
    #1;
    exp_q.delete();
    exp_stall  = 0;
    exp_bubble = 0;
    check_outputs();
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      in_valid = 1'($urandom);
      in_data  = rand_data();
      check_outputs();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    nRST     = 1'b1;
  endtask

  initial begin
    stat_clr = 1'b0;
    @(negedge CLK);
    // 1. Reset, then idle: stays empty until the first accept
    do_reset(3);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    // 2. Streaming 1..4 with out_ready high
    for (int i = 1; i <= 4; i++) cycle(1'b1, DATA_W'(i), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // 3. Backpressure: 0xA accepted, then out_ready low; 0xB to skid, 0xC held
    cycle(1'b1, 'hA, 1'b1, 1'b0);
    cycle(1'b1, 'hB, 1'b0, 1'b0);
    cycle(1'b1, 'hC, 1'b0, 1'b0);
    cycle(1'b1, 'hC, 1'b0, 1'b0);
    cycle(1'b1, 'hC, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // 4. Flush in TWO with 0x55 presented
    cycle(1'b1, 'h11, 1'b0, 1'b0);
    cycle(1'b1, 'h22, 1'b0, 1'b0);
    cycle(1'b1, 'h55, 1'b0, 1'b1);
    check("flush_two_data", out_data, '0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // 5. Flush together with pop in ONE
    cycle(1'b1, 'h33, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("flush_pop_data", out_data, '0);

`ifdef PIPE_STATS_EN
    // 6. Stall counter saturation and clear
    cycle(1'b1, 'h77, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, '0, 1'b0, 1'b0);
    check("stall_sat", DATA_W'(stall_cnt), DATA_W'(15));
    stat_clr = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);
    stat_clr = 1'b0;
    check("stall_clr", DATA_W'(stall_cnt), '0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
    check("bubble_inc", DATA_W'(bubble_cnt), DATA_W'(3));
`endif

    // Random traffic, with one mid-run reset
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        do_reset(2);
      end
      stat_clr = ($urandom_range(0, 99) < 3);
      cycle($urandom_range(0, 99) < 70, rand_data(),
            $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 5);
    end
    stat_clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
